// File: rtl/motor_cmd_spi_rx_pkg.sv
// Shared types and constants for the motor command SPI receiver.
package motor_cmd_pkg;

    localparam int unsigned FRAME_BITS    = 16;
    localparam logic [7:0]  STATUS_MARKER = 8'hA5;

    typedef struct packed {
        logic       sign;
        logic [6:0] count;
    } motor_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT,
        ABORT
    } rx_state_t;

    // Splits one frame byte into sign/count and clamps the count to full scale.
    function automatic motor_cmd_t decode_cmd(input logic [7:0] raw, input logic [6:0] max_count);
        motor_cmd_t c;
        c.sign  = raw[7];
        c.count = (raw[6:0] > max_count) ? max_count : raw[6:0];
        return c;
    endfunction

endpackage

// File: rtl/motor_cmd_spi_rx_if.sv
// SPI pins plus committed command outputs of motor_cmd_spi_rx.
// wdog_trip exists only when CMD_WATCHDOG_EN is defined.
interface motor_cmd_spi_rx_if;

    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       motor1_sign;
    logic [6:0] motor1_count;
    logic       motor2_sign;
    logic [6:0] motor2_count;
    logic       cmd_valid;
    logic       frame_err;
    logic [7:0] err_count;
`ifdef CMD_WATCHDOG_EN
    logic       wdog_trip;
`endif

    modport slave (
        input  sclk, cs_n, mosi,
        output miso, motor1_sign, motor1_count, motor2_sign, motor2_count,
        output cmd_valid, frame_err, err_count
`ifdef CMD_WATCHDOG_EN
        , output wdog_trip
`endif
    );

    modport master (
        output sclk, cs_n, mosi,
        input  miso, motor1_sign, motor1_count, motor2_sign, motor2_count,
        input  cmd_valid, frame_err, err_count
`ifdef CMD_WATCHDOG_EN
        , input wdog_trip
`endif
    );

endinterface

// File: rtl/motor_cmd_spi_rx_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/motor_cmd_spi_rx.sv
// SPI mode-0 slave receiving 16-bit motor commands; commits both motors atomically.
// Optional command watchdog enabled by defining CMD_WATCHDOG_EN.
module motor_cmd_spi_rx
    import motor_cmd_pkg::*;
#(
    parameter logic [6:0]  MAX_COUNT   = 7'd100,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [23:0] WDOG_CYCLES = 24'd600000
) (
    input  logic              clk,
    input  logic              reset,
    motor_cmd_spi_rx_if.slave bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || WDOG_CYCLES == '0) begin : g_param_check
        $error("motor_cmd_spi_rx: SYNC_STAGES must be 2..3 and WDOG_CYCLES nonzero");
    end

    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_unused_sclk_sync;
    logic                   w_cs_sync;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_mosi;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.sclk),
        .o_sync  (w_unused_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (bus.cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    rx_state_t   r_state;
    rx_state_t   w_state_next;
    logic [4:0]  r_bitcnt;
    logic [4:0]  w_bitcnt_next;
    logic        w_bit_take;
    logic [15:0] r_shift;

    // Bits past the over-length mark are dropped; the count then pins at 17.
    always_comb begin
        w_bit_take    = (r_state == SHIFT) && w_sclk_rise && (r_bitcnt != 5'(FRAME_BITS + 1));
        w_bitcnt_next = w_bit_take ? r_bitcnt + 5'd1 : r_bitcnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The length check uses the post-capture count so a bit landing with cs_n rise still counts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_state_next = (w_bitcnt_next == 5'(FRAME_BITS)) ? COMMIT : ABORT;
            COMMIT:  w_state_next = IDLE;
            ABORT:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (r_state == IDLE && w_cs_fall) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else if (w_bit_take) begin
            r_bitcnt <= w_bitcnt_next;
            r_shift  <= {r_shift[14:0], w_mosi};
        end
    end

    motor_cmd_t r_m1;
    motor_cmd_t r_m2;
    logic       r_cmd_valid;
    logic       r_frame_err;
    logic [7:0] r_err_count;
`ifdef CMD_WATCHDOG_EN
    logic [23:0] r_wdog_cnt;
    logic        r_wdog_trip;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m1        <= '0;
            r_m2        <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
`ifdef CMD_WATCHDOG_EN
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_state == COMMIT) begin
                r_m1        <= decode_cmd(r_shift[15:8], MAX_COUNT);
                r_m2        <= decode_cmd(r_shift[7:0], MAX_COUNT);
                r_cmd_valid <= 1'b1;
            end else if (r_state == ABORT) begin
                r_frame_err <= 1'b1;
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
`ifdef CMD_WATCHDOG_EN
            // Counts forced to zero stay there until the next commit reloads them.
            if (r_state == COMMIT) begin
                r_wdog_cnt  <= '0;
                r_wdog_trip <= 1'b0;
            end else begin
                if (r_wdog_cnt != '1) begin
                    r_wdog_cnt <= r_wdog_cnt + 24'd1;
                end
                if (r_wdog_cnt == WDOG_CYCLES) begin
                    r_wdog_trip  <= 1'b1;
                    r_m1.count   <= '0;
                    r_m2.count   <= '0;
                end
            end
`endif
        end
    end

    logic [15:0] r_miso_sr;
    logic [4:0]  r_miso_left;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miso_sr   <= '0;
            r_miso_left <= '0;
        end else if (w_cs_fall) begin
            r_miso_sr   <= {STATUS_MARKER, r_err_count};
            r_miso_left <= 5'(FRAME_BITS);
        end else if (w_cs_rise) begin
            r_miso_left <= '0;
        end else if (w_sclk_fall && !w_cs_sync && r_miso_left != '0) begin
            r_miso_sr   <= {r_miso_sr[14:0], 1'b0};
            r_miso_left <= r_miso_left - 5'd1;
        end
    end

    assign bus.miso         = !w_cs_sync && (r_miso_left != '0) && r_miso_sr[15];
    assign bus.motor1_sign  = r_m1.sign;
    assign bus.motor1_count = r_m1.count;
    assign bus.motor2_sign  = r_m2.sign;
    assign bus.motor2_count = r_m2.count;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.frame_err    = r_frame_err;
    assign bus.err_count    = r_err_count;
`ifdef CMD_WATCHDOG_EN
    assign bus.wdog_trip    = r_wdog_trip;
`endif

endmodule

// File: tb/tb_motor_cmd_spi_rx.sv
// Directed self-checking bench for motor_cmd_spi_rx (watchdog steps run when CMD_WATCHDOG_EN is defined).
module tb_motor_cmd_spi_rx;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    motor_cmd_spi_rx_if bus();

    motor_cmd_spi_rx #(
        .MAX_COUNT   (7'd100),
        .SYNC_STAGES (2),
        .WDOG_CYCLES (24'd1000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one chip-select window of nbits bits (MSB first), captures miso on each
    // sclk rise, then watches 16 clks after cs_n rise for pulses.
    task automatic spi_frame(input int unsigned nbits, input logic [31:0] data,
                             output logic [31:0] rx, output int unsigned n_valid,
                             output int unsigned n_err, output int unsigned lat);
        rx = '0; n_valid = 0; n_err = 0; lat = 0;
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = int'(nbits) - 1; i >= 0; i--) begin
            bus.mosi = data[i];
            repeat (4) @(negedge clk);
            rx = {rx[30:0], bus.miso};
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        bus.cs_n = 1'b1;
        for (int unsigned c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            if (bus.cmd_valid === 1'b1) begin
                n_valid++;
                if (lat == 0) lat = c;
            end
            if (bus.frame_err === 1'b1) n_err++;
        end
    endtask

    task automatic check_cmd(input string tag, input logic s1, input logic [6:0] c1,
                             input logic s2, input logic [6:0] c2);
        check({tag, ".m1_sign"},  32'(bus.motor1_sign),  32'(s1));
        check({tag, ".m1_count"}, 32'(bus.motor1_count), 32'(c1));
        check({tag, ".m2_sign"},  32'(bus.motor2_sign),  32'(s2));
        check({tag, ".m2_count"}, 32'(bus.motor2_count), 32'(c2));
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx;
        int unsigned nv, ne, lat;

        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        check_cmd("reset", 1'b0, 7'd0, 1'b0, 7'd0);
        check("reset.cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("reset.frame_err", 32'(bus.frame_err), 32'd0);
        check("reset.err_count", 32'(bus.err_count), 32'd0);
        check("reset.miso",      32'(bus.miso),      32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        spi_frame(16, 32'h9E32, rx, nv, ne, lat);
        check_cmd("f9E32", 1'b1, 7'd30, 1'b0, 7'd50);
        check("f9E32.valid_pulses", nv, 1);
        check("f9E32.latency",      lat, 4);
        check("f9E32.err_pulses",   ne, 0);

        spi_frame(16, 32'h7FFF, rx, nv, ne, lat);
        check_cmd("f7FFF", 1'b0, 7'd100, 1'b1, 7'd100);
        check("f7FFF.valid_pulses", nv, 1);

        spi_frame(16, 32'h8A0A, rx, nv, ne, lat);
        check_cmd("f8A0A", 1'b1, 7'd10, 1'b0, 7'd10);

        spi_frame(12, 32'hFFF, rx, nv, ne, lat);
        check_cmd("short", 1'b1, 7'd10, 1'b0, 7'd10);
        check("short.err_pulses",   ne, 1);
        check("short.valid_pulses", nv, 0);

        spi_frame(20, 32'hFFFFF, rx, nv, ne, lat);
        check_cmd("long", 1'b1, 7'd10, 1'b0, 7'd10);
        check("long.err_pulses", ne, 1);
        check("long.miso_bits",  rx & 32'hFFFFF, 32'hA5010);
        check("long.err_count",  32'(bus.err_count), 32'd2);

        spi_frame(16, 32'h8A0A, rx, nv, ne, lat);
        check("readback.miso_bits", rx & 32'hFFFF, 32'hA502);
        check("readback.valid_pulses", nv, 1);
        repeat (3) @(negedge clk);
        check("idle.miso", 32'(bus.miso), 32'd0);

        spi_frame(16, 32'hE4E5, rx, nv, ne, lat);
        check_cmd("clamp_edge", 1'b1, 7'd100, 1'b1, 7'd100);

        spi_frame(0, 32'h0, rx, nv, ne, lat);
        check("glitch.err_pulses", ne, 1);
        check("glitch.err_count",  32'(bus.err_count), 32'd3);
        check_cmd("glitch", 1'b1, 7'd100, 1'b1, 7'd100);

        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.mosi = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (4) @(negedge clk);
            bus.sclk = 1'b0;
        end
        reset = 1'b1;
        #1;
        check_cmd("midreset", 1'b0, 7'd0, 1'b0, 7'd0);
        check("midreset.err_count", 32'(bus.err_count), 32'd0);
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.cmd_valid === 1'b1 || bus.frame_err === 1'b1) nv++;
        end
        check("midreset.no_pulses", nv, 0);

        spi_frame(16, 32'h0505, rx, nv, ne, lat);
        check_cmd("f0505", 1'b0, 7'd5, 1'b0, 7'd5);
        check("f0505.err_count", 32'(bus.err_count), 32'd0);

`ifdef CMD_WATCHDOG_EN
        spi_frame(16, 32'h8A8A, rx, nv, ne, lat);
        check_cmd("f8A8A", 1'b1, 7'd10, 1'b1, 7'd10);
        check("f8A8A.wdog_trip", 32'(bus.wdog_trip), 32'd0);
        repeat (900) @(negedge clk);
        check("wdog.before_trip", 32'(bus.wdog_trip), 32'd0);
        check_cmd("wdog.before", 1'b1, 7'd10, 1'b1, 7'd10);
        repeat (150) @(negedge clk);
        check("wdog.tripped", 32'(bus.wdog_trip), 32'd1);
        check_cmd("wdog.forced", 1'b1, 7'd0, 1'b1, 7'd0);
        spi_frame(16, 32'h0101, rx, nv, ne, lat);
        check_cmd("f0101", 1'b0, 7'd1, 1'b0, 7'd1);
        check("f0101.wdog_trip", 32'(bus.wdog_trip), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_cmd_spi_rx.md
Name: motor_cmd_spi_rx

Overview:
- Upstream stage of motor_controller: SPI-mode-0 slave receiving motor commands from the balance MCU.
- Oversamples sclk/cs_n/mosi on the fabric clock, assembles 16-bit frames and clamps counts to MAX_COUNT.
- Commits both motor sign/count pairs atomically into the holding registers that drive motor_controller's motor1_sign/motor1_count/motor2_sign/motor2_count inputs.
- Discards malformed frames so the last good command stays in force.

Parameters:
- MAX_COUNT, 7'd100, upper clamp for received counts; matches motor_controller full-scale duty.
- SYNC_STAGES, 2, flip-flop stages on sclk, cs_n and mosi (range 2-3).
- WDOG_CYCLES, 24'd600000, clk cycles without a good frame before failsafe (used only with CMD_WATCHDOG_EN).

Ports:
- clk  input  1  fabric clock; must be >= 8x sclk frequency.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock from MCU, asynchronous; idles low.
- cs_n  input  1  SPI chip select, active low, asynchronous.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out; driven only while cs_n is low, 0 otherwise.
- motor1_sign  output  1  committed direction, motor 1.
- motor1_count  output  7  committed magnitude, motor 1.
- motor2_sign  output  1  committed direction, motor 2.
- motor2_count  output  7  committed magnitude, motor 2.
- cmd_valid  output  1  one-clk pulse on each commit.
- frame_err  output  1  one-clk pulse when a frame is discarded.
- err_count  output  8  discarded-frame count; saturates at 255.

Behaviour:
- Reset (async assert, sync release): all outputs 0 (signs 0, counts 0, miso 0, pulses 0, err_count 0); FSM to IDLE.
- Inputs pass through SYNC_STAGES flops.
- Edges are detected on the synchronized signals:
  - sclk rise: sample mosi.
  - sclk fall: advance miso.
  - cs_n fall: start of frame.
  - cs_n rise: end of frame.
- Frame format, 16 bits MSB first: [15] m1_sign, [14:8] m1_count, [7] m2_sign, [6:0] m2_count.
- FSM states: IDLE, SHIFT, COMMIT, ABORT.
  - IDLE -> SHIFT on cs_n fall. Clear bit counter (5 bits) and shift register.
  - SHIFT: each sclk rise shifts mosi into the shift register LSB and increments the bit counter.
  - SHIFT, cs_n rise with bitcnt == 16 -> COMMIT.
  - SHIFT, cs_n rise with bitcnt != 16 -> ABORT.
  - SHIFT, bitcnt reaches 17 (over-length) -> stay in SHIFT ignoring further bits; frame resolves to ABORT at cs_n rise.
  - COMMIT (1 cycle): load all four outputs in the same clk and pulse cmd_valid -> IDLE.
  - ABORT (1 cycle): pulse frame_err, err_count += 1 (saturating), outputs unchanged -> IDLE.
- Clamp: a received count greater than MAX_COUNT is committed as MAX_COUNT. The sign is kept.
- Latency: cmd_valid asserts 1 clk after the synchronized cs_n rise is detected. That is SYNC_STAGES+2 clks after the raw cs_n rise.
- miso response frame: 16 bits {8'hA5, err_count}, snapshotted at cs_n fall.
  - Bit 15 is presented immediately.
  - Each subsequent sclk fall shifts out the next bit.
  - After 16 bits, miso holds 0.
- sclk edges while cs_n is high are ignored.
- cs_n glitch (fall then rise with 0 bits) -> ABORT, counted as an error.
- Simultaneous cs_n rise and sclk rise in the same synchronized cycle: the bit is captured before the length check.
- Reset mid-frame: frame lost, outputs to 0, no pulses.

Optional Feature:
- Macro: CMD_WATCHDOG_EN.
- Defined:
  - 24-bit counter reloads to 0 on every COMMIT and increments otherwise, saturating.
  - On reaching WDOG_CYCLES, motor1_count and motor2_count are forced to 0 (signs held) and a wdog_trip output (1 bit, sticky) asserts.
  - The next COMMIT clears wdog_trip and restores normal updates.
  - Reset clears wdog_trip.
- Not defined: no counter, no wdog_trip port; last good command is held indefinitely.

Decomposition:
- Package motor_cmd_pkg:
  - typedef motor_cmd_t: packed struct {sign, count[6:0]}.
  - FRAME_BITS = 16, STATUS_MARKER = 8'hA5.
  - State enum {IDLE, SHIFT, COMMIT, ABORT}.
- One sub-module, spi_sync_edge: parameterized synchronizer plus rise/fall detector, instantiated for sclk and cs_n; mosi uses the sync only.

Test Plan:
- Reset, then send 16'h9E32 -> after commit: motor1_sign=1, motor1_count=30, motor2_sign=0, motor2_count=50; cmd_valid single pulse.
- Send 16'h7FFF -> motor1_sign=0, motor1_count=100, motor2_sign=1, motor2_count=100 (clamped).
- Good frame 16'h8A0A, then 12-bit frame, then 20-bit frame -> outputs stay at 1/10, 0/10; two frame_err pulses; err_count=2.
- Read back during next frame -> miso bits = 16'hA502 MSB first; miso 0 with cs_n high.
- Assert reset mid-frame after 8 bits -> all outputs 0 immediately; next good frame 16'h0505 commits 0/5, 0/5.
- With CMD_WATCHDOG_EN and WDOG_CYCLES=1000, commit 16'h8A8A then idle 1000 clks -> counts 0, signs 1, wdog_trip=1; next frame 16'h0101 clears wdog_trip and commits 0/1, 0/1.
